// File: rtl/mem_data_arbiter_if.sv
// mem_data_arbiter_if
//   Bundles the two requester ports and the memory-side data port of the
//   memory data arbiter.
//   Requester n (n = 0 CPU LSU, 1 loader/debug master):
//     mN_addr/mN_wdata/mN_write/mN_req -> arbiter
//     mN_rdata/mN_done/mN_err          <- arbiter
//   Memory side:
//     mem_addr/mem_wdata/mem_write/mem_req -> memory
//     mem_rdata/mem_done                   <- memory
//   Modports: slave = arbiter view, master = requesters + memory view.
interface mem_data_arbiter_if;
  logic [15:0] m0_addr;
  logic [7:0]  m0_wdata;
  logic        m0_write;
  logic        m0_req;
  logic [7:0]  m0_rdata;
  logic        m0_done;
  logic        m0_err;

  logic [15:0] m1_addr;
  logic [7:0]  m1_wdata;
  logic        m1_write;
  logic        m1_req;
  logic [7:0]  m1_rdata;
  logic        m1_done;
  logic        m1_err;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic        mem_req;
  logic [7:0]  mem_rdata;
  logic        mem_done;

  modport slave (
    input  m0_addr, m0_wdata, m0_write, m0_req,
    input  m1_addr, m1_wdata, m1_write, m1_req,
    input  mem_rdata, mem_done,
    output m0_rdata, m0_done, m0_err,
    output m1_rdata, m1_done, m1_err,
    output mem_addr, mem_wdata, mem_write, mem_req
  );

  modport master (
    output m0_addr, m0_wdata, m0_write, m0_req,
    output m1_addr, m1_wdata, m1_write, m1_req,
    output mem_rdata, mem_done,
    input  m0_rdata, m0_done, m0_err,
    input  m1_rdata, m1_done, m1_err,
    input  mem_addr, mem_wdata, mem_write, mem_req
  );
endinterface

// File: rtl/mem_data_arbiter.sv
// mem_data_arbiter
//   Shares the byte-wide memory data port between two requesters with
//   round-robin arbitration and one transaction in flight. Every access gets
//   an address-setup cycle ahead of mem_req so the memory's registered
//   read-modify-write merge sees the correct old word.
// Ports:
//   clock  - system clock
//   reset  - asynchronous active-low reset
//   bus    - mem_data_arbiter_if.slave (requester ports + memory data port)
//   busy   - high in any state other than IDLE
//   grant  - port currently or last granted
// Parameters:
//   TIMEOUT_CYCLES - ACCESS cycles before abort (1..65535), timeout build only
// Optional feature:
//   MEM_ARB_TIMEOUT_EN - when defined, an ACCESS that sees no mem_done within
//   TIMEOUT_CYCLES is aborted and reported with err=1 (read data 8'hFF).
//
//   state  | meaning
//   IDLE   | waiting for a request; arbitrates and latches the winner
//   SETUP  | address/data/write stable, mem_req low
//   ACCESS | mem_req high until mem_done (or timeout)
//   RESP   | one-cycle done pulse to the granted port
module mem_data_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  mem_data_arbiter_if.slave bus,
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       last_grant;
  logic       take;
  logic       sel;
  logic       finish;
  logic       tmo_hit;
  logic [7:0] cap_data;

  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("mem_data_arbiter: TIMEOUT_CYCLES must be 1..65535");
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    sel       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) begin
          take = 1'b1;
          sel  = ~last_grant;
        end else if (bus.m0_req) begin
          take = 1'b1;
          sel  = 1'b0;
        end else if (bus.m1_req) begin
          take = 1'b1;
          sel  = 1'b1;
        end
        if (take) state_nxt = SETUP;
      end
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (finish) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mem_done wins over a coincident timeout, so real data is never replaced.
  assign finish   = (state == ACCESS) && (bus.mem_done || tmo_hit);
  assign cap_data = bus.mem_done ? bus.mem_rdata : 8'hFF;

  // Gated combinationally so the memory never samples a second request in
  // the cycle it signals completion.
  assign bus.mem_req = (state == ACCESS) && !bus.mem_done;
  assign busy        = (state != IDLE);
  assign bus.m0_done = (state == RESP) && !grant;
  assign bus.m1_done = (state == RESP) && grant;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      bus.mem_addr  <= 16'h0000;
      bus.mem_wdata <= 8'h00;
      bus.mem_write <= 1'b0;
      bus.m0_rdata  <= 8'h00;
      bus.m1_rdata  <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == IDLE && take) begin
        grant         <= sel;
        last_grant    <= sel;
        bus.mem_addr  <= sel ? bus.m1_addr  : bus.m0_addr;
        bus.mem_wdata <= sel ? bus.m1_wdata : bus.m0_wdata;
        bus.mem_write <= sel ? bus.m1_write : bus.m0_write;
      end
      if (finish && !bus.mem_write) begin
        if (grant) bus.m1_rdata <= cap_data;
        else       bus.m0_rdata <= cap_data;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] acc_cnt;
  logic        err_q;

  // acc_cnt counts completed ACCESS cycles; the limit is hit in the last
  // allowed cycle so mem_req is high for exactly TIMEOUT_CYCLES cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_cnt <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      if (state == ACCESS) acc_cnt <= acc_cnt + 16'd1;
      else                 acc_cnt <= 16'h0000;
      if (finish) err_q <= !bus.mem_done;
    end
  end

  assign tmo_hit    = (acc_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign bus.m0_err = bus.m0_done && err_q;
  assign bus.m1_err = bus.m1_done && err_q;
`else
  assign tmo_hit    = 1'b0;
  assign bus.m0_err = 1'b0;
  assign bus.m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_data_arbiter.sv
// tb_mem_data_arbiter
//   Bench for mem_data_arbiter: memory model with RAM (1-cycle) and MMIO
//   (programmable latency, 0 = never) regions, per-port scoreboard queues
//   filled at issue and drained on done pulses.
module tb_mem_data_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic busy;
  logic grant;

  always #5 clock = ~clock;

  mem_data_arbiter_if bus ();

  mem_data_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .grant (grant)
  );

  typedef struct {
    logic       wr;
    logic [7:0] rdata;
    logic       err;
    int         req_cycles;
  } sb_entry_t;

  sb_entry_t  sb_q0[$];
  sb_entry_t  sb_q1[$];
  int         done_log[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         req_cnt = 0;
  int         mmio_lat = 20;
  int         mcnt;
  logic [7:0] ram    [0:65535];
  logic [7:0] shadow [0:65535];
  logic [7:0] last_rd [2];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int mem_lat(input logic [15:0] a);
    return (a >= 16'hF000) ? mmio_lat : 1;
  endfunction

  // memory model: registered, asserts mem_done after mem_lat() request cycles
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.mem_done  <= 1'b0;
      bus.mem_rdata <= 8'h00;
      mcnt          <= 0;
    end else if (bus.mem_done) begin
      bus.mem_done <= 1'b0;
    end else if (bus.mem_req) begin
      if (mem_lat(bus.mem_addr) != 0 && mcnt + 1 >= mem_lat(bus.mem_addr)) begin
        bus.mem_done <= 1'b1;
        mcnt         <= 0;
        if (bus.mem_write) begin
          if (bus.mem_addr < 16'hF000) ram[bus.mem_addr] <= bus.mem_wdata;
        end else begin
          bus.mem_rdata <= (bus.mem_addr >= 16'hF000) ? 8'h5A : ram[bus.mem_addr];
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  task automatic score(input int p);
    sb_entry_t e;
    logic [7:0] rd;
    if (p == 0) begin
      check_val("sb_nonempty0", 32'(sb_q0.size() != 0), 1);
      if (sb_q0.size() == 0) return;
      e  = sb_q0.pop_front();
      rd = bus.m0_rdata;
      check_val("err0", 32'(bus.m0_err), 32'(e.err));
    end else begin
      check_val("sb_nonempty1", 32'(sb_q1.size() != 0), 1);
      if (sb_q1.size() == 0) return;
      e  = sb_q1.pop_front();
      rd = bus.m1_rdata;
      check_val("err1", 32'(bus.m1_err), 32'(e.err));
    end
    check_val(e.wr ? "rdata_hold" : "rdata", 32'(rd), 32'(e.rdata));
    check_val("mem_req_cycles", req_cnt, e.req_cycles);
    done_log.push_back(p);
    req_cnt = 0;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      req_cnt = 0;
    end else begin
      if (bus.mem_req) req_cnt++;
      if (bus.m0_done || bus.m1_done) begin
        check_val("single_done", 32'(bus.m0_done & bus.m1_done), 0);
        if (bus.m0_done) score(0);
        else             score(1);
      end
    end
  end

  task automatic drive_port(input int p, input logic req, input logic wr,
                            input logic [15:0] a, input logic [7:0] d);
    if (p == 0) begin
      bus.m0_req = req; bus.m0_write = wr; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = req; bus.m1_write = wr; bus.m1_addr = a; bus.m1_wdata = d;
    end
  endtask

  // exp_lat = 0 skips the latency check (contended ports)
  task automatic txn(input int p, input logic wr, input logic [15:0] a, input logic [7:0] d,
                     input int exp_lat, input int exp_req, input logic exp_err);
    sb_entry_t e;
    int   start;
    logic got;
    e.wr         = wr;
    e.err        = exp_err;
    e.req_cycles = exp_req;
    if (wr) begin
      if (a < 16'hF000) shadow[a] = d;
      e.rdata = last_rd[p];
    end else begin
      e.rdata    = exp_err ? 8'hFF : ((a >= 16'hF000) ? 8'h5A : shadow[a]);
      last_rd[p] = e.rdata;
    end
    if (p == 0) sb_q0.push_back(e);
    else        sb_q1.push_back(e);
    start = cyc;
    drive_port(p, 1'b1, wr, a, d);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      got = (p == 0) ? bus.m0_done : bus.m1_done;
    end
    check_val("done_seen", 32'(got), 1);
    if (got && exp_lat > 0) check_val("latency", cyc - start, exp_lat);
    @(posedge clock);
    #1;
    drive_port(p, 1'b0, wr, a, d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    drive_port(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive_port(1, 1'b0, 1'b0, 16'h0000, 8'h00);

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_busy",     32'(busy), 0);
    check_val("rst_grant",    32'(grant), 0);
    check_val("rst_mem_req",  32'(bus.mem_req), 0);
    check_val("rst_mem_addr", 32'(bus.mem_addr), 0);
    check_val("rst_mem_wr",   32'(bus.mem_write), 0);
    check_val("rst_m0_rdata", 32'(bus.m0_rdata), 0);
    check_val("rst_m1_rdata", 32'(bus.m1_rdata), 0);
    check_val("rst_m0_done",  32'(bus.m0_done), 0);
    @(negedge clock);
    reset = 1'b1;

    // write then read back on port 0
    txn(0, 1'b1, 16'h0010, 8'hA5, 4, 1, 1'b0);
    txn(0, 1'b0, 16'h0010, 8'h00, 4, 1, 1'b0);

    // neighbouring bytes written by port 0, read back by port 1
    txn(0, 1'b1, 16'h0020, 8'h11, 4, 1, 1'b0);
    txn(0, 1'b1, 16'h0021, 8'h22, 4, 1, 1'b0);
    txn(1, 1'b0, 16'h0020, 8'h00, 4, 1, 1'b0);
    txn(1, 1'b0, 16'h0021, 8'h00, 4, 1, 1'b0);

    // contention: last grant was port 1, so port 0 leads and they alternate
    base = done_log.size();
    fork
      begin
        for (int i = 0; i < 3; i++) txn(0, 1'b1, 16'h0040 + 16'(i), 8'h30 + 8'(i), 0, 1, 1'b0);
      end
      begin
        txn(1, 1'b0, 16'h0010, 8'h00, 0, 1, 1'b0);
        txn(1, 1'b0, 16'h0020, 8'h00, 0, 1, 1'b0);
        txn(1, 1'b0, 16'h0021, 8'h00, 0, 1, 1'b0);
      end
    join
    check_val("rr_count", done_log.size() - base, 6);
    for (int i = 0; i < 6; i++)
      if (base + i < done_log.size()) check_val("rr_order", done_log[base + i], i % 2);

    // slow MMIO write on port 1
    mmio_lat = 20;
    txn(1, 1'b1, 16'hF000, 8'h0F, 23, 20, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
    // MMIO read that never completes
    mmio_lat = 0;
    txn(0, 1'b0, 16'hF000, 8'h00, 10, 8, 1'b1);
    mmio_lat = 20;
`endif

    // reset in the middle of ACCESS
    mmio_lat = 0;
    @(posedge clock);
    #1;
    drive_port(0, 1'b1, 1'b0, 16'hF000, 8'h00);
    repeat (2) @(posedge clock);
    #2;
    check_val("pre_rst_mem_req", 32'(bus.mem_req), 1);
    reset = 1'b0;
    #1;
    check_val("arst_mem_req", 32'(bus.mem_req), 0);
    check_val("arst_busy",    32'(busy), 0);
    check_val("arst_m0_done", 32'(bus.m0_done), 0);
    check_val("arst_m0_rdata", 32'(bus.m0_rdata), 0);
    drive_port(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    mmio_lat = 20;

    // tie after reset: port 0 first
    @(posedge clock);
    #1;
    base = done_log.size();
    fork
      txn(0, 1'b0, 16'h0020, 8'h00, 4, 1, 1'b0);
      txn(1, 1'b0, 16'h0021, 8'h00, 0, 1, 1'b0);
    join
    check_val("post_rst_count", done_log.size() - base, 2);
    if (done_log.size() >= base + 2) begin
      check_val("post_rst_first",  done_log[base], 0);
      check_val("post_rst_second", done_log[base + 1], 1);
    end

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
